// File: rtl/ram_word_master_if.sv
// Request/response handshakes and RAM-port signals of ram_word_master, bundled.
interface ram_word_master_if #(
  parameter int wordsize = 8,
  parameter int addrsize = 9,
  parameter int NB       = 4
) ();
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [addrsize-1:0]      req_addr;
  logic [wordsize*NB-1:0]   req_wdata;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [wordsize*NB-1:0]   resp_rdata;
  logic                     resp_error;
  logic [addrsize-1:0]      mem_addr;
  logic                     mem_wEn;
  logic [wordsize-1:0]      mem_wDat;
  logic                     mem_rEn;
  logic [wordsize-1:0]      mem_rDat;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready, mem_rDat,
    output req_ready, resp_valid, resp_rdata, resp_error,
           mem_addr, mem_wEn, mem_wDat, mem_rEn
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready, mem_rDat,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           mem_addr, mem_wEn, mem_wDat, mem_rEn
  );
endinterface

// File: rtl/ram_word_master.sv
// Word-level initiator: one NB-byte request becomes NB little-endian byte accesses
// on a single RAM port, followed by one response. All outputs are registered.
module ram_word_master #(
  parameter int wordsize  = 8,
  parameter int wordcount = 512,
  parameter int addrsize  = 9,
  parameter int NB        = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  ram_word_master_if.slave bus
);
  localparam int                 CW       = (NB > 1) ? $clog2(NB) : 1;
  localparam int                 DW       = wordsize * NB;
  localparam logic [CW-1:0]      CNT_LAST = CW'(NB - 1);
  localparam logic [addrsize:0]  SPAN     = (addrsize + 1)'(NB - 1);
  localparam logic [addrsize:0]  ADDR_MAX = (addrsize + 1)'(wordcount - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [addrsize-1:0]  r_addr, w_addr_nxt;
  logic                 r_write, w_write_nxt;
  logic [DW-1:0]        r_wdata, w_wdata_nxt;
  logic                 r_error, w_error_nxt;
  logic [DW-1:0]        r_rdata;
  logic                 w_accept;
  logic [addrsize:0]    w_end_addr;
  logic                 w_range_err;
  logic [wordsize-1:0]  w_wbyte;

  logic                 r_req_ready;
  logic                 r_resp_valid;
  logic [addrsize-1:0]  r_mem_addr;
  logic                 r_mem_wEn;
  logic                 r_mem_rEn;
  logic [wordsize-1:0]  r_mem_wDat;

  // Last byte address computed one bit wider so a request past the top never wraps.
  assign w_end_addr  = {1'b0, bus.req_addr} + SPAN;
  assign w_range_err = (w_end_addr > ADDR_MAX);
  assign w_wbyte     = w_wdata_nxt[int'(w_cnt_nxt) * wordsize +: wordsize];

  // Next-state and captured-request logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_write_nxt = r_write;
    w_wdata_nxt = r_wdata;
    w_error_nxt = r_error;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid && r_req_ready) begin
          w_accept    = 1'b1;
          w_addr_nxt  = bus.req_addr;
          w_write_nxt = bus.req_write;
          w_wdata_nxt = bus.req_wdata;
          w_cnt_nxt   = '0;
          if (w_range_err) begin
            w_state_nxt = ST_RESP;
            w_error_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_XFER;
            w_error_nxt = 1'b0;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_RESP;
          w_error_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, captured request and read-data assembly.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_error <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_write <= w_write_nxt;
      r_wdata <= w_wdata_nxt;
      r_error <= w_error_nxt;
      if (w_accept) begin
        r_rdata <= '0;
      end else if ((r_state == ST_XFER) && !r_write) begin
        r_rdata[int'(r_cnt) * wordsize +: wordsize] <= bus.mem_rDat;
      end
    end
  end

  // Output registers are loaded from the next state so they line up with it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wEn    <= 1'b0;
      r_mem_rEn    <= 1'b0;
      r_mem_wDat   <= '0;
    end else begin
      r_req_ready  <= (w_state_nxt == ST_IDLE);
      r_resp_valid <= (w_state_nxt == ST_RESP);
      if (w_state_nxt == ST_XFER) begin
        r_mem_addr <= w_addr_nxt + addrsize'(w_cnt_nxt);
        r_mem_wEn  <= w_write_nxt;
        r_mem_rEn  <= !w_write_nxt;
        r_mem_wDat <= w_write_nxt ? w_wbyte : {wordsize{1'b0}};
      end else begin
        r_mem_addr <= '0;
        r_mem_wEn  <= 1'b0;
        r_mem_rEn  <= 1'b0;
        r_mem_wDat <= '0;
      end
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_error = r_error;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wEn    = r_mem_wEn;
  assign bus.mem_rEn    = r_mem_rEn;
  assign bus.mem_wDat   = r_mem_wDat;
endmodule

// File: tb/tb_ram_word_master.sv
// Bench for ram_word_master: byte RAM model on the memory port, scoreboard of
// expected responses compared against handshaked responses.
module tb_ram_word_master;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  ram_word_master_if #(.wordsize(8), .addrsize(9), .NB(4)) bus ();

  ram_word_master #(.wordsize(8), .wordcount(512), .addrsize(9), .NB(4)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  logic [7:0] ram [512];
  always @(posedge clock) if (bus.mem_wEn) ram[bus.mem_addr] <= bus.mem_wDat;
  assign bus.mem_rDat = bus.mem_rEn ? ram[bus.mem_addr] : 8'h00;

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  typedef struct { logic [31:0] rdata; logic err; int c; } got_t;
  exp_t       exp_q[$];
  got_t       got_q[$];
  int         acc_q[$];
  logic [8:0] addr_log[$];
  int cyc = 0, n_wen = 0, n_ren = 0, n_both = 0;
  int total = 0, bad = 0;

  // Monitor: counts memory strobes, logs acceptances and responses per edge.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.mem_wEn) n_wen <= n_wen + 1;
    if (bus.mem_rEn) n_ren <= n_ren + 1;
    if (bus.mem_wEn && bus.mem_rEn) n_both <= n_both + 1;
    if (bus.mem_wEn || bus.mem_rEn) addr_log.push_back(bus.mem_addr);
    if (bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
    if (bus.resp_valid && bus.resp_ready) got_q.push_back('{bus.resp_rdata, bus.resp_error, cyc});
  end

  task automatic send(input logic wr, input logic [8:0] a, input logic [31:0] d, input bit hold);
    bus.req_write = wr; bus.req_addr = a; bus.req_wdata = d; bus.req_valid = 1'b1;
    for (int i = 0; i < 100 && !bus.req_ready; i++) @(negedge clock);
    @(posedge clock); @(negedge clock);
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic wait_got(output got_t g, output bit ok);
    for (int i = 0; i < 200 && got_q.size() == 0; i++) @(negedge clock);
    ok = (got_q.size() != 0);
    if (ok) g = got_q.pop_front();
    else g = '{32'h0, 1'b0, 0};
  endtask

  task automatic test_reset();
    @(negedge clock);
    total++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_error, bus.mem_addr,
         bus.mem_wEn, bus.mem_rEn, bus.mem_wDat} !== 54'h0) begin
      bad++; $display("FAIL reset_outs: outputs not all zero during reset");
    end
    reset_n = 1'b1;
    @(negedge clock);
    total++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      bad++; $display("FAIL ready_after_reset: ready=%b valid=%b want 1/0", bus.req_ready, bus.resp_valid);
    end
  endtask

  task automatic test_write_read();
    got_t g; exp_t e; bit ok; int w0, r0, a0;
    w0 = n_wen; r0 = n_ren; a0 = acc_q.size();
    exp_q.push_back('{32'h0, 1'b0});
    send(1'b1, 9'h010, 32'h12345678, 1'b0);
    wait_got(g, ok); e = exp_q.pop_front();
    total++;
    if (!ok || g.rdata !== e.rdata || g.err !== e.err) begin
      bad++; $display("FAIL wr_resp: ok=%0d rdata=%h err=%b want %h/%b", ok, g.rdata, g.err, e.rdata, e.err);
    end
    total++;
    if (g.c - acc_q[a0] !== 5) begin bad++; $display("FAIL wr_latency: got %0d want 5", g.c - acc_q[a0]); end
    total++;
    if (n_wen - w0 !== 4 || n_ren - r0 !== 0) begin
      bad++; $display("FAIL wr_strobes: wEn=%0d rEn=%0d want 4/0", n_wen - w0, n_ren - r0);
    end
    total++;
    if ({ram[9'h013], ram[9'h012], ram[9'h011], ram[9'h010]} !== 32'h12345678) begin
      bad++; $display("FAIL wr_bytes: got %h want 12345678", {ram[9'h013], ram[9'h012], ram[9'h011], ram[9'h010]});
    end
    r0 = n_ren; a0 = acc_q.size();
    exp_q.push_back('{32'h12345678, 1'b0});
    send(1'b0, 9'h010, 32'h0, 1'b0);
    wait_got(g, ok); e = exp_q.pop_front();
    total++;
    if (!ok || g.rdata !== e.rdata || g.err !== e.err) begin
      bad++; $display("FAIL rd_resp: ok=%0d rdata=%h err=%b want %h/%b", ok, g.rdata, g.err, e.rdata, e.err);
    end
    total++;
    if (g.c - acc_q[a0] !== 5 || n_ren - r0 !== 4) begin
      bad++; $display("FAIL rd_timing: lat=%0d rEn=%0d want 5/4", g.c - acc_q[a0], n_ren - r0);
    end
  endtask

  task automatic test_range();
    got_t g; exp_t e; bit ok; int w0, r0, a0, l0;
    exp_q.push_back('{32'h0, 1'b0});
    send(1'b1, 9'h1FC, 32'hCAFEF00D, 1'b0);
    wait_got(g, ok); e = exp_q.pop_front();
    total++;
    if (!ok || g.err !== e.err) begin bad++; $display("FAIL top_write: ok=%0d err=%b want 0", ok, g.err); end
    l0 = addr_log.size();
    exp_q.push_back('{32'hCAFEF00D, 1'b0});
    send(1'b0, 9'h1FC, 32'h0, 1'b0);
    wait_got(g, ok); e = exp_q.pop_front();
    total++;
    if (!ok || g.rdata !== e.rdata || g.err !== e.err) begin
      bad++; $display("FAIL top_read: rdata=%h err=%b want %h/%b", g.rdata, g.err, e.rdata, e.err);
    end
    total++;
    if (addr_log.size() - l0 !== 4) begin bad++; $display("FAIL top_addr_cnt: got %0d want 4", addr_log.size() - l0); end
    else for (int k = 0; k < 4; k++) begin
      total++;
      if (addr_log[l0 + k] !== 9'h1FC + 9'(k)) begin
        bad++; $display("FAIL top_addr_seq: got %h want %h", addr_log[l0 + k], 9'h1FC + 9'(k));
      end
    end
    w0 = n_wen; r0 = n_ren; a0 = acc_q.size();
    exp_q.push_back('{32'h0, 1'b1});
    send(1'b0, 9'h1FD, 32'h0, 1'b0);
    wait_got(g, ok); e = exp_q.pop_front();
    total++;
    if (!ok || g.rdata !== e.rdata || g.err !== e.err) begin
      bad++; $display("FAIL oor_read: rdata=%h err=%b want %h/%b", g.rdata, g.err, e.rdata, e.err);
    end
    total++;
    if (g.c - acc_q[a0] !== 1 || n_wen - w0 !== 0 || n_ren - r0 !== 0) begin
      bad++; $display("FAIL oor_read_timing: lat=%0d wEn=%0d rEn=%0d want 1/0/0", g.c - acc_q[a0], n_wen - w0, n_ren - r0);
    end
    w0 = n_wen;
    exp_q.push_back('{32'h0, 1'b1});
    send(1'b1, 9'h1FF, 32'h01020304, 1'b0);
    wait_got(g, ok); e = exp_q.pop_front();
    total++;
    if (!ok || g.rdata !== e.rdata || g.err !== e.err || n_wen - w0 !== 0) begin
      bad++; $display("FAIL oor_write: rdata=%h err=%b wEn=%0d want %h/%b/0", g.rdata, g.err, n_wen - w0, e.rdata, e.err);
    end
  endtask

  task automatic test_backpressure();
    got_t g; exp_t e; bit ok; int a0;
    bus.resp_ready = 1'b0; a0 = acc_q.size();
    exp_q.push_back('{32'h12345678, 1'b0});
    send(1'b0, 9'h010, 32'h0, 1'b1);
    bus.req_write = 1'b1; bus.req_addr = 9'h030; bus.req_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 20 && !bus.resp_valid; i++) @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h12345678 || bus.req_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold: valid=%b rdata=%h ready=%b want 1/12345678/0", bus.resp_valid, bus.resp_rdata, bus.req_ready);
      end
      if (k < 2) @(negedge clock);
    end
    total++;
    if (acc_q.size() - a0 !== 1) begin bad++; $display("FAIL bp_no_accept: accepts=%0d want 1", acc_q.size() - a0); end
    bus.resp_ready = 1'b1;
    wait_got(g, ok); e = exp_q.pop_front();
    total++;
    if (!ok || g.rdata !== e.rdata || g.err !== e.err) begin
      bad++; $display("FAIL bp_resp: rdata=%h err=%b want %h/%b", g.rdata, g.err, e.rdata, e.err);
    end
    exp_q.push_back('{32'h0, 1'b0});
    @(posedge clock); @(negedge clock);
    bus.req_valid = 1'b0;
    total++;
    if (acc_q.size() - a0 !== 2 || acc_q[acc_q.size() - 1] !== g.c + 1) begin
      bad++; $display("FAIL bp_next_accept: accepts=%0d at %0d want 2 at %0d", acc_q.size() - a0, acc_q[acc_q.size() - 1], g.c + 1);
    end
    wait_got(g, ok); e = exp_q.pop_front();
    total++;
    if (!ok || g.rdata !== e.rdata || g.err !== e.err) begin
      bad++; $display("FAIL bp_second: rdata=%h err=%b want %h/%b", g.rdata, g.err, e.rdata, e.err);
    end
  endtask

  task automatic test_back_to_back();
    got_t g; exp_t e; bit ok; int a0;
    logic [31:0] vals [3];
    logic [8:0]  addrs [3];
    vals[0] = 32'h0BADF00D; vals[1] = 32'h5A5AA5A5; vals[2] = 32'hFFFF0001;
    addrs[0] = 9'h040; addrs[1] = 9'h044; addrs[2] = 9'h100;
    a0 = acc_q.size();
    for (int i = 0; i < 6; i++) begin
      bus.req_write = (i % 2 == 0); bus.req_addr = addrs[i / 2];
      bus.req_wdata = vals[i / 2]; bus.req_valid = 1'b1;
      exp_q.push_back('{(i % 2 == 0) ? 32'h0 : vals[i / 2], 1'b0});
      for (int j = 0; j < 50 && !bus.req_ready; j++) @(negedge clock);
      @(posedge clock); @(negedge clock);
    end
    bus.req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wait_got(g, ok); e = exp_q.pop_front();
      total++;
      if (!ok || g.rdata !== e.rdata || g.err !== e.err) begin
        bad++; $display("FAIL b2b_resp%0d: rdata=%h err=%b want %h/%b", i, g.rdata, g.err, e.rdata, e.err);
      end
    end
    total++;
    if (acc_q.size() - a0 !== 6) begin bad++; $display("FAIL b2b_count: got %0d want 6", acc_q.size() - a0); end
    else for (int i = 0; i < 5; i++) begin
      total++;
      if (acc_q[a0 + i + 1] - acc_q[a0 + i] !== 6) begin
        bad++; $display("FAIL b2b_spacing: got %0d want 6", acc_q[a0 + i + 1] - acc_q[a0 + i]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    got_t g; exp_t e; bit ok;
    exp_q.push_back('{32'h0, 1'b0});
    send(1'b1, 9'h020, 32'h11223344, 1'b0);
    wait_got(g, ok); e = exp_q.pop_front();
    total++;
    if (!ok || g.err !== e.err) begin bad++; $display("FAIL pre_write: ok=%0d err=%b want 0", ok, g.err); end
    send(1'b1, 9'h020, 32'hAABBCCDD, 1'b0);
    @(negedge clock); @(negedge clock);
    total++;
    if (bus.mem_addr !== 9'h022 || bus.mem_wEn !== 1'b1 || bus.mem_wDat !== 8'hBB) begin
      bad++; $display("FAIL mid_byte2: addr=%h wEn=%b wDat=%h want 022/1/bb", bus.mem_addr, bus.mem_wEn, bus.mem_wDat);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_error, bus.mem_addr,
         bus.mem_wEn, bus.mem_rEn, bus.mem_wDat} !== 54'h0) begin
      bad++; $display("FAIL async_reset: outputs not zero right after reset assertion");
    end
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) @(negedge clock);
    total++;
    if (bus.req_ready !== 1'b1 || got_q.size() !== 0) begin
      bad++; $display("FAIL abort_resp: ready=%b responses=%0d want 1/0", bus.req_ready, got_q.size());
    end
    total++;
    if ({ram[9'h023], ram[9'h022], ram[9'h021], ram[9'h020]} !== 32'h1122CCDD) begin
      bad++; $display("FAIL abort_bytes: got %h want 1122ccdd", {ram[9'h023], ram[9'h022], ram[9'h021], ram[9'h020]});
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 9'h0;
    bus.req_wdata = 32'h0; bus.resp_ready = 1'b1;
    test_reset();
    test_write_read();
    test_range();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_write();
    total++;
    if (n_both !== 0) begin bad++; $display("FAIL strobe_excl: both strobes high %0d cycles", n_both); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
